// File: rtl/foo_lane_tx_if.sv
// Word-in handshake bundle for foo_lane_tx: valid/ready plus payload and destination lane.
// Latency: none, wires only.
// Backpressure: producer holds in_valid/in_data/in_lane stable until in_ready is high at a clock edge.
//
// Signals:
//   in_valid  producer -> transmitter  word available
//   in_ready  transmitter -> producer  word will be taken at the next rising edge
//   in_data   producer -> transmitter  payload, DATA_W bits
//   in_lane   producer -> transmitter  destination lane index, LANE_W bits
interface foo_lane_tx_if #(
    parameter int DATA_W = 8,
    parameter int LANE_W = 2
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [LANE_W-1:0] in_lane;

    modport master (
        output in_valid,
        output in_data,
        output in_lane,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_lane,
        output in_ready
    );
endinterface

// File: rtl/foo_lane_tx.sv
// Serialises parallel words into framed bit streams on one of N 1-bit lanes (foos[i].a).
// Latency: start bit on lane_a one cycle after accept; frame is DATA_W+2 cycles (DATA_W+3 with parity).
// Backpressure: in_ready low from accept until the STOP cycle; upstream holds its word meanwhile.
//
// Ports:
//   clk, rst_n   rising-edge clock; asynchronous active-low reset
//   in_if        slave side of foo_lane_tx_if (in_valid/in_ready/in_data/in_lane)
//   lane_a[N]    lane_a[i] drives foos[i].a; idle level 0
//   busy         high from the start bit through the STOP bit
//   lane_err     one-cycle pulse after a word addressed to a lane >= N was consumed and dropped
//   tx_count     completed frames, 16-bit wrapping
//
// Build option: define FOO_LANE_TX_PARITY_EN to insert an even-parity bit (^data) after the data bits.
// Frame: START(1), data LSB first, [PARITY], STOP(0). All outputs come straight from flops.
module foo_lane_tx #(
    parameter int N      = 4,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    foo_lane_tx_if.slave    in_if,
    output logic [N-1:0]    lane_a,
    output logic            busy,
    output logic            lane_err,
    output logic [15:0]     tx_count
);

    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int LAST_I = DATA_W - 1;

    // Lane limit one bit wider than the index so N = 2**LANE_W still compares correctly.
    localparam logic [LANE_W:0]    N_LIM    = N[LANE_W:0];
    localparam logic [CNT_W-1:0]   LAST_BIT = LAST_I[CNT_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic [LANE_W-1:0]   lane_q,     lane_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [N-1:0]        lane_a_q,   lane_a_d;
    logic                busy_q,     busy_d;
    logic                ready_q,    ready_d;
    logic                err_q,      err_d;
    logic [15:0]         tx_count_q, tx_count_d;

    // Bit and lane that lane_a will show during the next cycle.
    logic                tx_bit;
    logic [LANE_W-1:0]   tx_lane;

    logic                accept;
    logic                lane_ok;
    logic [LANE_W-1:0]   lane_eff;
    logic [CNT_W-1:0]    cnt_nxt;

    // A single-lane build ignores the index entirely; otherwise indices >= N are rejected.
    always_comb begin
        if (N == 1) begin
            lane_eff = '0;
            lane_ok  = 1'b1;
        end else begin
            lane_eff = in_if.in_lane;
            lane_ok  = ({1'b0, in_if.in_lane} < N_LIM);
        end
    end

    // ready_q is only ever high in IDLE and STOP, so it alone qualifies the handshake.
    assign accept  = in_if.in_valid && ready_q;
    assign cnt_nxt = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        err_d      = 1'b0;
        tx_count_d = tx_count_q;
        tx_bit     = 1'b0;
        tx_lane    = lane_q;

        case (state_q)
            // STOP shares IDLE's accept path so a held in_valid starts the next
            // frame right after the single STOP zero.
            S_IDLE, S_STOP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (accept) begin
                    if (lane_ok) begin
                        state_d = S_START;
                        data_d  = in_if.in_data;
                        lane_d  = lane_eff;
                        tx_bit  = 1'b1;
                        tx_lane = lane_eff;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        // Word consumed but dropped; transmitter stays available.
                        err_d = 1'b1;
                    end
                end
            end

            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
                tx_bit  = data_q[0];
            end

            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
`ifdef FOO_LANE_TX_PARITY_EN
                    state_d = S_PARITY;
                    tx_bit  = ^data_q;
`else
                    state_d    = S_STOP;
                    tx_bit     = 1'b0;
                    ready_d    = 1'b1;
                    tx_count_d = tx_count_q + 16'd1;
`endif
                end else begin
                    cnt_d  = cnt_nxt;
                    tx_bit = data_q[cnt_nxt];
                end
            end

`ifdef FOO_LANE_TX_PARITY_EN
            S_PARITY: begin
                state_d    = S_STOP;
                tx_bit     = 1'b0;
                ready_d    = 1'b1;
                tx_count_d = tx_count_q + 16'd1;
            end
`endif

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase

        // Only the selected lane ever carries the frame; all others stay at idle 0.
        for (int i = 0; i < N; i++) begin
            lane_a_d[i] = tx_bit && (tx_lane == LANE_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            lane_q     <= '0;
            cnt_q      <= '0;
            lane_a_q   <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            tx_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            lane_a_q   <= lane_a_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign lane_a         = lane_a_q;
    assign busy           = busy_q;
    assign lane_err       = err_q;
    assign tx_count       = tx_count_q;
    assign in_if.in_ready = ready_q;

endmodule

// File: tb/tb_foo_lane_tx.sv
// Bench for foo_lane_tx: N=4 instance for framing, back-to-back, parity and reset;
// N=3 instance for the out-of-range lane drop.
module tb_foo_lane_tx;
    localparam int N      = 4;
    localparam int DATA_W = 8;
`ifdef FOO_LANE_TX_PARITY_EN
    localparam int L = DATA_W + 3;
`else
    localparam int L = DATA_W + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    foo_lane_tx_if #(.DATA_W(DATA_W), .LANE_W(2)) if4 ();
    foo_lane_tx_if #(.DATA_W(DATA_W), .LANE_W(2)) if3 ();

    logic [3:0]  lane_a4;
    logic        busy4, err4;
    logic [15:0] txc4;
    logic [2:0]  lane_a3;
    logic        busy3, err3;
    logic [15:0] txc3;

    foo_lane_tx #(.N(4), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_if    (if4),
        .lane_a   (lane_a4),
        .busy     (busy4),
        .lane_err (err4),
        .tx_count (txc4)
    );

    foo_lane_tx #(.N(3), .DATA_W(DATA_W)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_if    (if3),
        .lane_a   (lane_a3),
        .busy     (busy3),
        .lane_err (err3),
        .tx_count (txc3)
    );

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int tx_exp   = 0;

    logic [3:0] sb[$];       // expected lane_a per frame cycle
    bit         stopq[$];    // marks the STOP entry of each frame
    logic [7:0] stim_d[$];
    logic [1:0] stim_l[$];
    int         acc_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [1:0] l);
        logic [3:0] one;
        one = 4'b0001 << l;
        sb.push_back(one);
        stopq.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) begin
            sb.push_back(d[i] ? one : 4'b0000);
            stopq.push_back(1'b0);
        end
`ifdef FOO_LANE_TX_PARITY_EN
        sb.push_back((^d) ? one : 4'b0000);
        stopq.push_back(1'b0);
`endif
        sb.push_back(4'b0000);
        stopq.push_back(1'b1);
    endtask

    task automatic present();
        if4.in_valid = 1'b1;
        if4.in_data  = stim_d[0];
        if4.in_lane  = stim_l[0];
    endtask

    // Each iteration: decide whether the coming edge accepts, advance one cycle,
    // then compare every output against the scoreboard.
    task automatic run(input int cycles);
        logic       acc;
        logic       exp_busy;
        logic [3:0] exp_a;
        for (int c = 0; c < cycles; c++) begin
            if (!if4.in_valid && stim_d.size() > 0) present();
            acc = if4.in_valid && if4.in_ready;
            if (acc) begin
                push_frame(stim_d[0], stim_l[0]);
                void'(stim_d.pop_front());
                void'(stim_l.pop_front());
                acc_log.push_back(cyc);
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (stim_d.size() > 0) present();
                else begin
                    if4.in_valid = 1'b0;
                    if4.in_data  = 8'($urandom);
                    if4.in_lane  = 2'($urandom);
                end
            end
            exp_busy = (sb.size() > 0);
            exp_a    = exp_busy ? sb.pop_front() : 4'b0000;
            if (exp_busy && stopq.pop_front()) tx_exp++;
            check("lane_a", 32'(lane_a4), 32'(exp_a));
            check("busy", 32'(busy4), 32'(exp_busy));
            check("in_ready", 32'(if4.in_ready), 32'(sb.size() == 0));
            check("lane_err", 32'(err4), 32'd0);
            check("tx_count", 32'(txc4), 32'(tx_exp[15:0]));
        end
    endtask

    initial begin
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_lane = '0;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.in_lane = '0;

        // Reset state
        #12;
        check("rst_lane_a", 32'(lane_a4), 32'd0);
        check("rst_ready", 32'(if4.in_ready), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_txc", 32'(txc4), 32'd0);
        #10 rst_n = 1'b1;
        #1;
        check("rel_ready_pre_edge", 32'(if4.in_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_ready", 32'(if4.in_ready), 32'd1);
        check("rel_lane_a", 32'(lane_a4), 32'd0);
        check("rel_busy", 32'(busy4), 32'd0);
        check("rel_txc", 32'(txc4), 32'd0);

        // Single frame 0xA5 on lane 2
        stim_d.push_back(8'hA5); stim_l.push_back(2'd2);
        run(L + 3);
        check("a5_txc", 32'(txc4), 32'd1);

        // Back-to-back with in_valid held: next accept exactly L cycles later
        acc_log.delete();
        stim_d.push_back(8'h01); stim_l.push_back(2'd0);
        stim_d.push_back(8'hFF); stim_l.push_back(2'd3);
        run(2 * L + 3);
        check("b2b_accepts", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) check("b2b_period", 32'(acc_log[1] - acc_log[0]), 32'(L));
        check("b2b_txc", 32'(txc4), 32'd3);

        // Parity-sensitive payloads (odd and even weight)
        stim_d.push_back(8'h07); stim_l.push_back(2'd1);
        stim_d.push_back(8'h03); stim_l.push_back(2'd3);
        run(2 * L + 3);
        check("par_txc", 32'(txc4), 32'd5);

        // Reset during data bit 4 of 0xFF on lane 1
        stim_d.push_back(8'hFF); stim_l.push_back(2'd1);
        run(6);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_lane_a", 32'(lane_a4), 32'd0);
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_txc", 32'(txc4), 32'd0);
        sb.delete(); stopq.delete(); stim_d.delete(); stim_l.delete();
        if4.in_valid = 1'b0;
        tx_exp = 0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("rerel_ready_pre_edge", 32'(if4.in_ready), 32'd0);
        @(posedge clk); #1;
        check("rerel_ready", 32'(if4.in_ready), 32'd1);
        check("rerel_lane_a", 32'(lane_a4), 32'd0);
        stim_d.push_back(8'h3C); stim_l.push_back(2'd0);
        run(L + 2);
        check("3c_txc", 32'(txc4), 32'd1);

        // N=3 instance: lane 3 is out of range, word dropped
        check("n3_ready_before", 32'(if3.in_ready), 32'd1);
        if3.in_valid = 1'b1; if3.in_data = 8'h5A; if3.in_lane = 2'd3;
        @(posedge clk); #1;
        if3.in_valid = 1'b0;
        check("n3_err_pulse", 32'(err3), 32'd1);
        check("n3_lane_a", 32'(lane_a3), 32'd0);
        check("n3_ready", 32'(if3.in_ready), 32'd1);
        check("n3_busy", 32'(busy3), 32'd0);
        @(posedge clk); #1;
        check("n3_err_clear", 32'(err3), 32'd0);
        check("n3_lane_a_after", 32'(lane_a3), 32'd0);
        check("n3_txc", 32'(txc3), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
